// File: rtl/fortaegis_pkg.sv
// rtl/fortaegis_pkg.sv - shared types and helpers for the Fortaegis capture buffer
package fortaegis_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    function automatic int fortaegis_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Channel i of a packed multi-channel word of w-bit samples
    `define FORTAEGIS_CHAN(data, i, w) ((data)[(i)*(w) +: (w)])

endpackage

// File: rtl/fortaegis_collect_buf_if.sv
// rtl/fortaegis_collect_buf_if.sv - frame readout stream between capture buffer and readout
interface fortaegis_collect_buf_if #(parameter int DW = 64);
    logic          valid;
    logic          ready;
    logic          last;
    logic [DW-1:0] data;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fortaegis_sdp_ram.sv
// rtl/fortaegis_sdp_ram.sv - simple dual-port RAM with registered, resettable read data
module fortaegis_sdp_ram
    import fortaegis_pkg::*;
#(
    parameter  int DW    = 64,
    parameter  int DEPTH = 64,
    localparam int AW    = fortaegis_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // q only moves on a read, so it also serves as the held output stage
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (re) q <= mem[raddr];
    end

endmodule

// File: rtl/fortaegis_collect_buf.sv
// rtl/fortaegis_collect_buf.sv - multi-channel pre/post-trigger capture ring with stream drain
module fortaegis_collect_buf
    import fortaegis_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int W     = 16,
    parameter  int DEPTH = 64,
    parameter  int POST  = 16,
    localparam int AW    = fortaegis_clog2(DEPTH)
) (
    input  logic                 clk350,
    input  logic                 rst,
    input  logic                 collect,
    input  logic                 rearm,
    input  logic [NCH*W-1:0]     sens_data,
    fortaegis_collect_buf_if.master out,
    output logic [AW:0]          frames,
    output logic                 busy,
    output logic                 ovf
);

    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_N = AW'(POST);

    state_t        state;
    logic          prev;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW:0]   rd_cnt;

    logic          fall;
    logic          wr_en;
    logic          rd_en;
    logic          accept;
    logic [AW:0]   frames_inc;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] rd_start;

    always_comb begin
        fall       = prev & ~collect;
        wr_en      = (state == S_ARMED) || (state == S_POST);
        accept     = out.valid && out.ready;
        rd_en      = (state == S_DRAIN) && (rd_cnt != frames) && (!out.valid || out.ready);
        frames_inc = (frames == FULL) ? frames : frames + 1'b1;
        wr_next    = wr_ptr + 1'b1;
        // Oldest frame once the ring has filled is the slot after the final write
        rd_start   = (frames_inc == FULL) ? wr_next : '0;
    end

    assign busy = (state != S_IDLE);

    fortaegis_sdp_ram #(.DW(NCH*W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk350),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (sens_data),
        .re    (rd_en),
        .raddr (rd_ptr),
        .q     (out.data)
    );

    always_ff @(posedge clk350) begin
        if (rst) begin
            state     <= S_IDLE;
            prev      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            post_cnt  <= '0;
            frames    <= '0;
            ovf       <= 1'b0;
            out.valid <= 1'b0;
            out.last  <= 1'b0;
        end else begin
            prev <= collect;
            if (wr_en) begin
                wr_ptr <= wr_next;
                frames <= frames_inc;
            end
            case (state)
                S_IDLE: begin
                    if (collect) begin
                        state  <= S_ARMED;
                        frames <= '0;
                        ovf    <= 1'b0;
                        wr_ptr <= '0;
                    end
                end
                S_ARMED: begin
                    if (frames == FULL) ovf <= 1'b1;
                    if (fall) begin
                        post_cnt <= POST_N;
                        if (POST == 0) begin
                            state  <= S_DRAIN;
                            rd_cnt <= '0;
                            rd_ptr <= rd_start;
                        end else begin
                            state <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    post_cnt <= post_cnt - 1'b1;
                    if (post_cnt == AW'(1)) begin
                        state  <= S_DRAIN;
                        rd_cnt <= '0;
                        rd_ptr <= rd_start;
                    end
                end
                S_DRAIN: begin
                    if (rd_en) begin
                        rd_ptr    <= rd_ptr + 1'b1;
                        rd_cnt    <= rd_cnt + 1'b1;
                        out.valid <= 1'b1;
                        out.last  <= ((rd_cnt + 1'b1) == frames);
                    end else if (accept) begin
                        out.valid <= 1'b0;
                        out.last  <= 1'b0;
                    end
                    if (accept && out.last) begin
                        if (rearm) begin
                            state  <= S_ARMED;
                            frames <= '0;
                            ovf    <= 1'b0;
                            wr_ptr <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fortaegis_collect_buf.sv
// tb/tb_fortaegis_collect_buf.sv - randomized model-checked bench for fortaegis_collect_buf
module tb_fortaegis_collect_buf;

    localparam int NCH   = 4;
    localparam int W     = 16;
    localparam int DEPTH = 64;
    localparam int POST  = 16;
    localparam int DW    = NCH * W;

    logic          clk350 = 1'b0;
    logic          rst = 1'b1;
    logic          collect = 1'b0;
    logic          rearm = 1'b0;
    logic [DW-1:0] sens_data = '0;
    logic [6:0]    frames;
    logic          busy, ovf;

    logic          collect_b = 1'b0;
    logic [DW-1:0] sens_b = '0;
    logic [6:0]    frames_b;
    logic          busy_b, ovf_b;

    fortaegis_collect_buf_if #(.DW(DW)) bus ();
    fortaegis_collect_buf_if #(.DW(DW)) bus_b ();

    fortaegis_collect_buf #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .POST(POST)) dut (
        .clk350(clk350), .rst(rst), .collect(collect), .rearm(rearm), .sens_data(sens_data),
        .out(bus), .frames(frames), .busy(busy), .ovf(ovf)
    );

    fortaegis_collect_buf #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .POST(0)) dut_b (
        .clk350(clk350), .rst(rst), .collect(collect_b), .rearm(1'b0), .sens_data(sens_b),
        .out(bus_b), .frames(frames_b), .busy(busy_b), .ovf(ovf_b)
    );

    always #5 clk350 = ~clk350;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_g = 0;

    logic [63:0] exp_q[$];
    int          exp_frames;
    bit          exp_ovf;
    bit          done, started, held;
    logic [63:0] held_data, first_data, last_data;
    int          n_acc, first_cyc, last_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk350) cyc_g++;

    // Every cycle a frame is offered it must be the model's oldest outstanding frame
    always @(negedge clk350) begin
        if (!rst && bus.valid) begin
            if (held) chk("hold_data", bus.data, held_data);
            if (exp_q.size() == 0) begin
                chk("extra_frame", 64'd1, 64'd0);
            end else begin
                chk("data", bus.data, exp_q[0]);
                chk("last", 64'(bus.last), 64'(exp_q.size() == 1));
                chk("frames", 64'(frames), 64'(exp_frames));
                chk("ovf", 64'(ovf), 64'(exp_ovf));
                chk("busy", 64'(busy), 64'd1);
                if (!started) begin
                    started    = 1'b1;
                    first_cyc  = cyc_g;
                    first_data = bus.data;
                end
                if (bus.ready) begin
                    last_data = bus.data;
                    last_cyc  = cyc_g;
                    n_acc++;
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) done = 1'b1;
                end
            end
        end
        held      = !rst && bus.valid && !bus.ready;
        held_data = bus.data;
    end

    task automatic step();
        @(posedge clk350);
        #1;
    endtask

    task automatic start_track();
        exp_q.delete();
        done    = 1'b0;
        started = 1'b0;
        held    = 1'b0;
        n_acc   = 0;
    endtask

    function automatic logic [DW-1:0] pick(input bit idx, input int c);
        return idx ? DW'(c) : {$urandom, $urandom};
    endfunction

    task automatic put(input bit idx, input int c);
        sens_data = pick(idx, c);
        exp_q.push_back(sens_data);
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    endtask

    // Drives one capture window; the model keeps the newest DEPTH of the written samples
    task automatic capture(input int nhigh, input bit from_idle, input bit idx, input bit keep);
        int c;
        int nwr;
        c = 0;
        start_track();
        nwr = from_idle ? nhigh - 1 : nhigh;
        if (from_idle) begin
            collect   = 1'b1;
            sens_data = pick(idx, c);
            c++;
            step();
        end
        repeat (nwr) begin
            collect = 1'b1;
            put(idx, c); c++;
            step();
        end
        collect = 1'b0;
        put(idx, c); c++;
        step();
        repeat (POST) begin
            collect = 1'($urandom_range(0, 1));
            put(idx, c); c++;
            step();
        end
        collect    = keep;
        exp_ovf    = (nwr + 1) > DEPTH;
        exp_frames = exp_q.size();
    endtask

    task automatic drain(input bit rnd);
        int t;
        t = 0;
        while (!done && t < 3000) begin
            bus.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            t++;
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(bus.valid), 64'd0);
        chk({tag, "_last"}, 64'(bus.last), 64'd0);
        chk({tag, "_data"}, bus.data, 64'd0);
        chk({tag, "_frames"}, 64'(frames), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic test_short(input string tag);
        capture(10, 1'b1, 1'b1, 1'b0);
        drain(1'b0);
        chk({tag, "_first"}, first_data, 64'd1);
        chk({tag, "_lastval"}, last_data, 64'd26);
        chk({tag, "_count"}, 64'(n_acc), 64'd26);
        chk({tag, "_frames"}, 64'(frames), 64'd26);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_span"}, 64'(last_cyc - first_cyc + 1), 64'd26);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ready   = 1'b0;
        bus_b.ready = 1'b0;
        start_track();
        repeat (3) step();
        chk_reset("rst0");
        chk("rst0_b_valid", 64'(bus_b.valid), 64'd0);
        chk("rst0_b_busy", 64'(busy_b), 64'd0);
        rst = 1'b0;
        step();

        // Zero post-trigger window: one sample, one frame
        collect_b = 1'b1; sens_b = 64'hdead_beef_0bad_f00d;
        step();
        collect_b = 1'b0; sens_b = 64'h1234_5678_9abc_def0;
        step();
        chk("p0_entry_valid", 64'(bus_b.valid), 64'd0);
        sens_b = '0;
        step();
        chk("p0_valid", 64'(bus_b.valid), 64'd1);
        chk("p0_data", bus_b.data, 64'h1234_5678_9abc_def0);
        chk("p0_last", 64'(bus_b.last), 64'd1);
        chk("p0_frames", 64'(frames_b), 64'd1);
        chk("p0_ovf", 64'(ovf_b), 64'd0);
        step();
        chk("p0_hold", bus_b.data, 64'h1234_5678_9abc_def0);
        bus_b.ready = 1'b1;
        step();
        chk("p0_after_valid", 64'(bus_b.valid), 64'd0);
        chk("p0_after_busy", 64'(busy_b), 64'd0);
        step();
        chk("p0_no_second", 64'(bus_b.valid), 64'd0);

        test_short("t1");

        // Ring overflow before trigger
        capture(100, 1'b1, 1'b1, 1'b0);
        drain(1'b0);
        chk("t2_first", first_data, 64'd53);
        chk("t2_lastval", last_data, 64'd116);
        chk("t2_count", 64'(n_acc), 64'd64);
        chk("t2_frames", 64'(frames), 64'd64);
        chk("t2_ovf", 64'(ovf), 64'd1);
        chk("t2_span", 64'(last_cyc - first_cyc + 1), 64'd64);

        capture(30, 1'b1, 1'b0, 1'b0);
        drain(1'b1);
        chk("t3_count", 64'(n_acc), 64'd46);
        chk("t3_busy", 64'(busy), 64'd0);

        for (int w = 0; w < 8; w++) begin
            int k;
            int nf;
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 48) : $urandom_range(65, 110);
            capture(k, 1'b1, 1'b0, 1'b0);
            nf = exp_frames;
            drain(1'($urandom_range(0, 1)));
            chk("rnd_count", 64'(n_acc), 64'(nf));
            chk("rnd_busy", 64'(busy), 64'd0);
            chk("rnd_valid", 64'(bus.valid), 64'd0);
            repeat ($urandom_range(0, 3)) step();
        end

        // Re-arm: second window starts immediately after the first drain
        rearm = 1'b1;
        capture(8, 1'b1, 1'b0, 1'b1);
        drain(1'b0);
        chk("ra_frames0", 64'(frames), 64'd0);
        chk("ra_busy", 64'(busy), 64'd1);
        chk("ra_valid", 64'(bus.valid), 64'd0);
        rearm = 1'b0;
        capture(12, 1'b0, 1'b0, 1'b0);
        chk("ra_model_frames", 64'(exp_frames), 64'd29);
        drain(1'b1);
        chk("ra_count", 64'(n_acc), 64'd29);
        chk("ra_idle", 64'(busy), 64'd0);

        // Reset while recording post-trigger samples
        start_track();
        collect = 1'b1;
        repeat (5) step();
        collect = 1'b0;
        step();
        repeat (3) step();
        chk("rp_busy_pre", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        chk_reset("rp");
        rst = 1'b0;
        step();

        // Reset part way through a drain
        capture(20, 1'b1, 1'b0, 1'b0);
        bus.ready = 1'b1;
        repeat (10) step();
        chk("rd_partial", 64'(done), 64'd0);
        rst = 1'b1;
        step();
        chk_reset("rd");
        rst = 1'b0;
        start_track();
        step();

        test_short("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
